// File: rtl/fu_logic_pkg.sv
// Shared opcode definitions for the logic functional unit.
package fu_pkg;

  localparam int unsigned OP_WIDTH = 3;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_AND     = 3'd0,
    OP_OR      = 3'd1,
    OP_XOR     = 3'd2,
    OP_ANDN    = 3'd3,
    OP_SLL     = 3'd4,
    OP_SRL     = 3'd5,
    OP_SRA     = 3'd6,
    OP_ILLEGAL = 3'd7
  } op_e;

endpackage

// File: rtl/fu_logic_alu.sv
// Combinational operation decode for fu_logic.
// Shift operations exist only when FU_LOGIC_SHIFT_EN is defined; otherwise they decode as illegal.
module fu_logic_alu
  import fu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [OP_WIDTH-1:0]   op,
  input  logic [DATA_WIDTH-1:0] data_0,
  input  logic [DATA_WIDTH-1:0] data_1,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  err
);

`ifdef FU_LOGIC_SHIFT_EN
  localparam int unsigned SHW = $clog2(DATA_WIDTH);
  logic [SHW-1:0] shamt;
  assign shamt = data_1[SHW-1:0];
`endif

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (op_e'(op))
      OP_AND:  result = data_0 & data_1;
      OP_OR:   result = data_0 | data_1;
      OP_XOR:  result = data_0 ^ data_1;
      OP_ANDN: result = data_0 & ~data_1;
`ifdef FU_LOGIC_SHIFT_EN
      OP_SLL:  result = data_0 << shamt;
      OP_SRL:  result = data_0 >> shamt;
      OP_SRA:  result = $unsigned($signed(data_0) >>> shamt);
`endif
      default: begin
        result = '0;
        err    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/fu_logic.sv
// Pipelined logic functional unit with issue/queued handshake and flush.
// Optional shifter enabled by defining FU_LOGIC_SHIFT_EN.
module fu_logic
  import fu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned TAG_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [OP_WIDTH-1:0]   op,
  input  logic [TAG_WIDTH-1:0]  executionTag_in,
  input  logic [DATA_WIDTH-1:0] data_0,
  input  logic [DATA_WIDTH-1:0] data_1,
  input  logic                  flush,
  input  logic                  queued,
  output logic                  idle,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [TAG_WIDTH-1:0]  executionTag_out,
  output logic                  err
);

  logic [LATENCY-1:0]    valid_q, valid_d;
  logic [TAG_WIDTH-1:0]  tag_q    [LATENCY];
  logic [TAG_WIDTH-1:0]  tag_d    [LATENCY];
  logic [DATA_WIDTH-1:0] result_q [LATENCY];
  logic [DATA_WIDTH-1:0] result_d [LATENCY];
  logic [LATENCY-1:0]    err_q, err_d;

  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_err;
  logic                  advance;
  logic                  issue;

  fu_logic_alu #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .op     (op),
    .data_0 (data_0),
    .data_1 (data_1),
    .result (alu_result),
    .err    (alu_err)
  );

  assign advance = ~valid_q[LATENCY-1] | queued;
  assign issue   = ce & advance;

  // Payload only moves behind a valid bit, so bubbles leave stale data in place.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    result_d = result_q;
    err_d    = err_q;
    if (flush) begin
      valid_d = '0;
    end else if (advance) begin
      valid_d[0] = issue;
      if (issue) begin
        tag_d[0]    = executionTag_in;
        result_d[0] = alu_result;
        err_d[0]    = alu_err;
      end
      for (int unsigned i = 1; i < LATENCY; i++) begin
        valid_d[i] = valid_q[i-1];
        if (valid_q[i-1]) begin
          tag_d[i]    = tag_q[i-1];
          result_d[i] = result_q[i-1];
          err_d[i]    = err_q[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        tag_q[i]    <= '0;
        result_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      err_q    <= err_d;
      tag_q    <= tag_d;
      result_q <= result_d;
    end
  end

  assign idle             = advance;
  assign done             = valid_q[LATENCY-1];
  assign result           = result_q[LATENCY-1];
  assign executionTag_out = tag_q[LATENCY-1];
  assign err              = err_q[LATENCY-1];

endmodule

// File: tb/tb_fu_logic.sv
// Self-checking bench for fu_logic: directed scenarios plus randomized traffic
// against a queue-based in-flight model.
module tb_fu_logic;

  localparam int unsigned DW  = 32;
  localparam int unsigned TW  = 7;
  localparam int unsigned LAT = 3;
`ifdef FU_LOGIC_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic [2:0]    op;
  logic [TW-1:0] tag_in;
  logic [DW-1:0] d0, d1;
  logic          flush;
  logic          queued;
  logic          idle, done, err;
  logic [DW-1:0] result;
  logic [TW-1:0] tag_out;

  fu_logic #(
    .DATA_WIDTH (DW),
    .LATENCY    (LAT),
    .TAG_WIDTH  (TW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .ce               (ce),
    .op               (op),
    .executionTag_in  (tag_in),
    .data_0           (d0),
    .data_1           (d1),
    .flush            (flush),
    .queued           (queued),
    .idle             (idle),
    .done             (done),
    .result           (result),
    .executionTag_out (tag_out),
    .err              (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned   pos;
    logic [DW-1:0] res;
    logic [TW-1:0] tag;
    logic          err;
  } op_t;

  op_t q[$];
  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic void expect_op(input logic [2:0] o, input logic [DW-1:0] a,
                                    input logic [DW-1:0] b,
                                    output logic [DW-1:0] r, output logic e);
    int unsigned sh;
    sh = b % DW;
    e  = 1'b0;
    r  = '0;
    case (o)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = a & ~b;
      3'd4, 3'd5, 3'd6: begin
        if (!SHIFT_EN) e = 1'b1;
        else if (o == 3'd4) r = a << sh;
        else if (o == 3'd5) r = a >> sh;
        else r = $unsigned($signed(a) >>> sh);
      end
      default: e = 1'b1;
    endcase
  endfunction

  function automatic bit model_done();
    return (q.size() > 0) && (q[0].pos == LAT - 1);
  endfunction

  // Apply the effect of one clock edge with the currently driven inputs.
  task automatic model_edge();
    bit adv;
    op_t n;
    adv = !model_done() || queued;
    if (flush) begin
      q.delete();
    end else if (adv) begin
      if (model_done()) void'(q.pop_front());
      foreach (q[k]) q[k].pos++;
      if (ce) begin
        expect_op(op, d0, d1, n.res, n.err);
        n.pos = 0;
        n.tag = tag_in;
        q.push_back(n);
      end
    end
  endtask

  // Called at posedge+1 with inputs already driven; ends at the next posedge+1.
  task automatic cycle();
    #1;
    check("idle", {63'd0, idle}, {63'd0, (!model_done() || queued)});
    check("done", {63'd0, done}, {63'd0, model_done()});
    if (model_done()) begin
      check("result", {32'd0, result}, {32'd0, q[0].res});
      check("tag", {57'd0, tag_out}, {57'd0, q[0].tag});
      check("err", {63'd0, err}, {63'd0, q[0].err});
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic c, input logic [2:0] o, input logic [TW-1:0] t,
                       input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic f, input logic qd);
    ce = c; op = o; tag_in = t; d0 = a; d1 = b; flush = f; queued = qd;
  endtask

  task automatic idle_cycles(input int unsigned n, input logic qd);
    for (int unsigned i = 0; i < n; i++) begin
      drive(1'b0, 3'd0, '0, '0, '0, 1'b0, qd);
      cycle();
    end
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_done"}, {63'd0, done}, 64'd0);
    check({pfx, "_result"}, {32'd0, result}, 64'd0);
    check({pfx, "_tag"}, {57'd0, tag_out}, 64'd0);
    check({pfx, "_err"}, {63'd0, err}, 64'd0);
    check({pfx, "_idle"}, {63'd0, idle}, 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b0);
    #12;
    check_zero_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // AND with queued held: result after LAT cycles
    drive(1'b1, 3'd0, 7'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1'b1);
    cycle();
    idle_cycles(LAT + 1, 1'b1);

    // back-to-back XOR, OR, ANDN
    drive(1'b1, 3'd2, 7'd1, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b1); cycle();
    drive(1'b1, 3'd1, 7'd2, 32'hA000_0005, 32'h0500_00A0, 1'b0, 1'b1); cycle();
    drive(1'b1, 3'd3, 7'd3, 32'hFFFF_FFFF, 32'h00FF_00FF, 1'b0, 1'b1); cycle();
    idle_cycles(LAT + 1, 1'b1);

    // stall: op reaches output, queued low while ce keeps trying
    drive(1'b1, 3'd1, 7'd9, 32'h0000_00F0, 32'h0000_000F, 1'b0, 1'b1); cycle();
    drive(1'b1, 3'd2, 7'd10, 32'h5555_5555, 32'hFFFF_0000, 1'b0, 1'b1); cycle();
    for (int unsigned i = 0; i < LAT + 5; i++) begin
      drive(1'b1, 3'd0, 7'd77, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      cycle();
    end
    idle_cycles(LAT + 2, 1'b1);

    // shifts and illegal op
    drive(1'b1, 3'd6, 7'd20, 32'h8000_0000, 32'h0000_0021, 1'b0, 1'b1); cycle();
    drive(1'b1, 3'd4, 7'd21, 32'h0000_0001, 32'h0000_001F, 1'b0, 1'b1); cycle();
    drive(1'b1, 3'd5, 7'd22, 32'h8000_0000, 32'hFFFF_FFE4, 1'b0, 1'b1); cycle();
    drive(1'b1, 3'd7, 7'd23, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1); cycle();
    idle_cycles(LAT + 1, 1'b1);

    // flush together with a third issue
    drive(1'b1, 3'd0, 7'd30, 32'hFFFF_FFFF, 32'h1111_1111, 1'b0, 1'b1); cycle();
    drive(1'b1, 3'd1, 7'd31, 32'h2222_2222, 32'h1111_1111, 1'b0, 1'b1); cycle();
    drive(1'b1, 3'd2, 7'd32, 32'h3333_3333, 32'h1111_1111, 1'b1, 1'b1); cycle();
    idle_cycles(LAT + 2, 1'b1);

    // asynchronous reset between edges with ops in flight
    drive(1'b1, 3'd1, 7'd40, 32'h00FF_0000, 32'h0000_00FF, 1'b0, 1'b1); cycle();
    drive(1'b1, 3'd2, 7'd41, 32'h0F0F_0000, 32'h0000_F0F0, 1'b0, 1'b1); cycle();
    drive(1'b1, 3'd3, 7'd42, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b0, 1'b1); cycle();
    drive(1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_zero_outputs("async_rst");
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycles(LAT + 2, 1'b1);

    // randomized traffic
    for (int unsigned i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), 7'($urandom),
            $urandom, $urandom, ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6));
      cycle();
    end
    idle_cycles(LAT + 2, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
